// File: rtl/cmp_pkg.sv
// Shared types and default sizes for the min/max burst sequencer.
package cmp_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mag_cmp.sv
// Combinational unsigned magnitude comparator: a against b.
module mag_cmp #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             a_eq_b,
    output logic             a_gt_b,
    output logic             a_lt_b
);

    // Unsigned relational decode of the two operands
    always_comb begin
        a_eq_b = (a == b);
        a_gt_b = (a > b);
        a_lt_b = (a < b);
    end

endmodule

// File: rtl/cmp_minmax_seq.sv
// Burst min/max/argmax sequencer around shared magnitude comparators.
// Optional CMP_STATS_EN adds out_eq_cnt (operands after the first tying the running max).
module cmp_minmax_seq
    import cmp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_min,
    output logic [CNT_W-1:0] out_max_idx,
    output logic             out_empty,
    output logic             busy
`ifdef CMP_STATS_EN
    ,
    output logic [CNT_W-1:0] out_eq_cnt
`endif
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] max_q, max_d;
    logic [WIDTH-1:0] min_q, min_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             empty_q, empty_d;
    logic             in_ready_q, out_valid_q, busy_q;
`ifdef CMP_STATS_EN
    logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
`endif

    logic max_eq_s, max_gt_s, max_lt_s;
    logic min_eq_s, min_gt_s, min_lt_s;
    logic unused_cmp_s;

    mag_cmp #(.WIDTH(WIDTH)) u_cmp_max (
        .a      (in_data),
        .b      (max_q),
        .a_eq_b (max_eq_s),
        .a_gt_b (max_gt_s),
        .a_lt_b (max_lt_s)
    );

    mag_cmp #(.WIDTH(WIDTH)) u_cmp_min (
        .a      (in_data),
        .b      (min_q),
        .a_eq_b (min_eq_s),
        .a_gt_b (min_gt_s),
        .a_lt_b (min_lt_s)
    );

    assign unused_cmp_s = ^{max_eq_s, max_lt_s, min_eq_s, min_gt_s};

    // Next-state, counter and result-register update
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        max_d    = max_q;
        min_d    = min_q;
        idx_d    = idx_q;
        empty_d  = empty_q;
`ifdef CMP_STATS_EN
        eq_cnt_d = eq_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d    = len;
                    cnt_d    = {CNT_W{1'b0}};
                    max_d    = {WIDTH{1'b0}};
                    min_d    = {WIDTH{1'b0}};
                    idx_d    = {CNT_W{1'b0}};
                    empty_d  = (len == {CNT_W{1'b0}});
`ifdef CMP_STATS_EN
                    eq_cnt_d = {CNT_W{1'b0}};
`endif
                    state_d  = (len == {CNT_W{1'b0}}) ? DONE : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (in_valid) begin
                    if (cnt_q == {CNT_W{1'b0}}) begin
                        max_d = in_data;
                        min_d = in_data;
                        idx_d = {CNT_W{1'b0}};
                    end else begin
                        // Strict compares keep the earliest index on ties
                        if (max_gt_s) begin
                            max_d = in_data;
                            idx_d = cnt_q;
                        end else begin
                            max_d = max_q;
                        end
                        if (min_lt_s) begin
                            min_d = in_data;
                        end else begin
                            min_d = min_q;
                        end
`ifdef CMP_STATS_EN
                        if (max_eq_s) begin
                            eq_cnt_d = eq_cnt_q + CNT_W'(1);
                        end else begin
                            eq_cnt_d = eq_cnt_q;
                        end
`endif
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == (len_q - CNT_W'(1))) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= {CNT_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            max_q       <= {WIDTH{1'b0}};
            min_q       <= {WIDTH{1'b0}};
            idx_q       <= {CNT_W{1'b0}};
            empty_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef CMP_STATS_EN
            eq_cnt_q    <= {CNT_W{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            max_q       <= max_d;
            min_q       <= min_d;
            idx_q       <= idx_d;
            empty_q     <= empty_d;
            in_ready_q  <= (state_d == RUN);
            out_valid_q <= (state_d == DONE);
            busy_q      <= (state_d != IDLE);
`ifdef CMP_STATS_EN
            eq_cnt_q    <= eq_cnt_d;
`endif
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign out_max     = max_q;
    assign out_min     = min_q;
    assign out_max_idx = idx_q;
    assign out_empty   = empty_q;
`ifdef CMP_STATS_EN
    assign out_eq_cnt  = eq_cnt_q;
`endif

endmodule
